// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution sequencer: FSM encodings and kernel geometry.
package conv_pkg;

  localparam int KSIZE   = 3;
  localparam int NTAPS   = 9;
  localparam int MAC_LAT = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TAP   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/conv_tap_gen.sv
// Window and tap counters for the 3x3 walk; addresses are built from incremental adds only.
module conv_tap_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int PIX_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              issue,
  input  logic              out_adv,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [3:0]        coef_idx,
  output logic              last_tap,
  output logic              last_out
);

  localparam logic [1:0]        KMAX      = 2'(KSIZE - 1);
  localparam logic [3:0]        CMAX      = 4'(NTAPS - 1);
  localparam logic [PIX_AW-1:0] ONE       = PIX_AW'(1);
  localparam logic [PIX_AW-1:0] W_STEP    = PIX_AW'(IMG_W);
  localparam logic [PIX_AW-1:0] ROW_WRAP  = PIX_AW'(KSIZE);
  localparam logic [PIX_AW-1:0] COL_MAX   = PIX_AW'(IMG_W - 3);
  localparam logic [PIX_AW-1:0] ROW_MAX   = PIX_AW'(IMG_H - 3);

  logic [1:0]        kx_r, ky_r;
  logic [3:0]        coef_r;
  logic [PIX_AW-1:0] row_off_r, base_r, col_r, row_r;
  logic [PIX_AW-1:0] pix_addr_r;
  logic [3:0]        coef_idx_r;
  logic              last_tap_r;
  logic [PIX_AW-1:0] base_nxt_s, col_nxt_s, row_nxt_s;

  // Next window origin; a row wrap moves base from (r,W-3) to (r+1,0), i.e. +3.
  always_comb begin
    base_nxt_s = base_r;
    col_nxt_s  = col_r;
    row_nxt_s  = row_r;
    if (out_adv) begin
      if (col_r == COL_MAX) begin
        col_nxt_s  = '0;
        row_nxt_s  = row_r + ONE;
        base_nxt_s = base_r + ROW_WRAP;
      end else begin
        col_nxt_s  = col_r + ONE;
        row_nxt_s  = row_r;
        base_nxt_s = base_r + ONE;
      end
    end else begin
      base_nxt_s = base_r;
      col_nxt_s  = col_r;
      row_nxt_s  = row_r;
    end
  end

  // Tap counters and registered address/coefficient outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx_r <= 2'd0; ky_r <= 2'd0; coef_r <= 4'd0;
      row_off_r <= '0; base_r <= '0; col_r <= '0; row_r <= '0;
      pix_addr_r <= '0; coef_idx_r <= 4'd0; last_tap_r <= 1'b0;
    end else if (clr) begin
      kx_r <= 2'd0; ky_r <= 2'd0; coef_r <= 4'd0;
      row_off_r <= '0; base_r <= '0; col_r <= '0; row_r <= '0;
      pix_addr_r <= '0; coef_idx_r <= 4'd0; last_tap_r <= 1'b0;
    end else begin
      base_r <= base_nxt_s;
      col_r  <= col_nxt_s;
      row_r  <= row_nxt_s;
      if (issue) begin
        // base_nxt_s so the first tap of a new output sees the advanced origin.
        pix_addr_r <= base_nxt_s + row_off_r + PIX_AW'(kx_r);
        coef_idx_r <= coef_r;
        last_tap_r <= (coef_r == CMAX);
        if (kx_r == KMAX) begin
          kx_r <= 2'd0;
          if (ky_r == KMAX) begin
            ky_r <= 2'd0; row_off_r <= '0; coef_r <= 4'd0;
          end else begin
            ky_r <= ky_r + 2'd1; row_off_r <= row_off_r + W_STEP; coef_r <= coef_r + 4'd1;
          end
        end else begin
          kx_r <= kx_r + 2'd1; coef_r <= coef_r + 4'd1;
        end
      end else begin
        pix_addr_r <= '0; coef_idx_r <= 4'd0; last_tap_r <= 1'b0;
      end
    end
  end

  assign pix_addr = pix_addr_r;
  assign coef_idx = coef_idx_r;
  assign last_tap = last_tap_r;
  assign last_out = (row_r == ROW_MAX) && (col_r == COL_MAX);

endmodule

// File: rtl/conv_seq_ctrl.sv
// 3x3 valid-only convolution sequencer: FSM, MAC enable pipe, result addressing and host handshake.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int PIX_AW = 5,
  parameter int RES_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [3:0]        coef_idx,
  output logic              mac_en,
  output logic              mac_first,
  output logic              res_we,
  output logic [RES_AW-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  logic [2:0]        state_r, state_nxt_s;
  logic [RES_AW-1:0] res_cnt_r, res_addr_r;
  logic              mac_en_r, mac_first_r, res_we_r, busy_r, done_r;
  logic              last_tap_s, last_out_s, clr_s, issue_s, out_adv_s, feed_s;

  // Next-state selection; abort outranks every transition out of a non-idle state.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:  if (start && !abort) state_nxt_s = ST_TAP;   else state_nxt_s = ST_IDLE;
      ST_TAP:   if (abort)           state_nxt_s = ST_IDLE;
                else if (last_tap_s) state_nxt_s = ST_DRAIN;
                else                 state_nxt_s = ST_TAP;
      ST_DRAIN: if (abort)           state_nxt_s = ST_IDLE;  else state_nxt_s = ST_WRITE;
      ST_WRITE: if (abort)           state_nxt_s = ST_IDLE;
                else if (last_out_s) state_nxt_s = ST_DONE;
                else                 state_nxt_s = ST_TAP;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  assign clr_s     = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
  assign issue_s   = (state_nxt_s == ST_TAP);
  assign out_adv_s = (state_r == ST_WRITE) && (state_nxt_s == ST_TAP);
  // A pixel issued this cycle returns next cycle unless the pass is being abandoned.
  assign feed_s    = (state_r == ST_TAP) && (state_nxt_s != ST_IDLE);

  conv_tap_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_AW (PIX_AW)
  ) u_tap_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .issue    (issue_s),
    .out_adv  (out_adv_s),
    .pix_addr (pix_addr),
    .coef_idx (coef_idx),
    .last_tap (last_tap_s),
    .last_out (last_out_s)
  );

  // State, result counter and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      res_cnt_r   <= '0;
      res_addr_r  <= '0;
      mac_en_r    <= 1'b0;
      mac_first_r <= 1'b0;
      res_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (clr_s) begin
        res_cnt_r <= '0;
      end else if (out_adv_s) begin
        res_cnt_r <= res_cnt_r + RES_AW'(1);
      end else begin
        res_cnt_r <= res_cnt_r;
      end
      mac_en_r    <= feed_s;
      mac_first_r <= feed_s && (coef_idx == 4'd0);
      res_we_r    <= (state_nxt_s == ST_WRITE);
      res_addr_r  <= (state_nxt_s == ST_WRITE) ? res_cnt_r : '0;
      busy_r      <= (state_nxt_s == ST_TAP) || (state_nxt_s == ST_DRAIN) ||
                     (state_nxt_s == ST_WRITE);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign mac_en    = mac_en_r;
  assign mac_first = mac_first_r;
  assign res_we    = res_we_r;
  assign res_addr  = res_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: per-cycle output schedule, MAC result model, abort/reset cases.
module tb_conv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [4:0] pix_a, pix_b;
  logic [3:0] coef_a, coef_b, raddr_a, raddr_b;
  logic       en_a, first_a, we_a, busy_a, done_a;
  logic       en_b, first_b, we_b, busy_b, done_b;

  int n_chk = 0;
  int n_pass = 0;
  int rd_a = 0;
  int acc_a = 0;
  int res_mem [0:15];

  conv_seq_ctrl u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .pix_addr(pix_a), .coef_idx(coef_a), .mac_en(en_a), .mac_first(first_a),
    .res_we(we_a), .res_addr(raddr_a), .busy(busy_a), .done(done_a)
  );

  conv_seq_ctrl #(.IMG_W(6), .IMG_H(4), .PIX_AW(5), .RES_AW(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .pix_addr(pix_b), .coef_idx(coef_b), .mac_en(en_b), .mac_first(first_b),
    .res_we(we_b), .res_addr(raddr_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Datapath model for instance A: mem[i]=i with 1-cycle read, all coefficients 1.
  always @(posedge clk) begin
    rd_a <= int'(pix_a);
    if (en_a) acc_a <= first_a ? rd_a : acc_a + rd_a;
    if (we_a) res_mem[raddr_a] <= acc_a;
  end

  function automatic int pack(int pix, int coef, int raddr, int en, int first, int we, int bsy, int dn);
    return pix * 65536 + coef * 4096 + raddr * 64 + en * 32 + first * 16 + we * 8 + bsy * 4 + dn * 2;
  endfunction

  // Expected outputs in cycle c after the start edge (cycle 1 = first TAP).
  function automatic int exp_vec(int w, int h, int c);
    int n, o, p, r, cl, base;
    n = (w - 2) * (h - 2);
    if (c >= 1 && c <= n * 11) begin
      o = (c - 1) / 11;
      p = (c - 1) % 11;
      r = o / (w - 2);
      cl = o % (w - 2);
      base = r * w + cl;
      if (p < 9) return pack(base + (p / 3) * w + (p % 3), p, 0, (p >= 1) ? 1 : 0, (p == 1) ? 1 : 0, 0, 1, 0);
      if (p == 9) return pack(0, 0, 0, 1, 0, 0, 1, 0);
      return pack(0, 0, o, 0, 0, 1, 1, 0);
    end
    if (c == n * 11 + 1) return pack(0, 0, 0, 0, 0, 0, 0, 1);
    return 0;
  endfunction

  function automatic int obs_a();
    return pack(int'(pix_a), int'(coef_a), int'(raddr_a), int'(en_a), int'(first_a), int'(we_a), int'(busy_a), int'(done_a));
  endfunction

  function automatic int obs_b();
    return pack(int'(pix_b), int'(coef_b), int'(raddr_b), int'(en_b), int'(first_b), int'(we_b), int'(busy_b), int'(done_b));
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full pass on A; optional extra start at cycle 'extra' and a start during the DONE cycle.
  task automatic run_a(input string tag, input int extra, input bit dstart);
    start_a = 1'b1;
    for (int c = 1; c <= 102; c++) begin
      tick();
      start_a = (c == extra) || (dstart && c == 100);
      chk($sformatf("%s c=%0d", tag, c), obs_a(), exp_vec(5, 5, c));
    end
    start_a = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_a", obs_a(), 0);
    chk("reset_b", obs_b(), 0);
    tick();
    rst = 1'b1;

    // Reset in the middle of output 3's taps.
    start_a = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      start_a = 1'b0;
      chk($sformatf("pre_rst c=%0d", c), obs_a(), exp_vec(5, 5, c));
    end
    #2 rst = 1'b0;
    #1 chk("rst_async", obs_a(), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_idle", obs_a(), 0);

    run_a("pass1", 0, 1'b0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("result %0d", i), res_mem[i], 9 * ((i / 3) * 5 + (i % 3)) + 54);

    run_a("pass_restart", 40, 1'b1);

    // Abort with a simultaneous start in IDLE.
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("abort_idle", obs_a(), 0);

    // Abort during the WRITE cycle of output 8.
    start_a = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      tick();
      start_a = 1'b0;
      abort_a = (c == 99);
      chk($sformatf("abort c=%0d", c), obs_a(), (c <= 99) ? exp_vec(5, 5, c) : 0);
    end
    abort_a = 1'b0;

    // 6x4 image on instance B.
    start_b = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      tick();
      start_b = 1'b0;
      chk($sformatf("w6h4 c=%0d", c), obs_b(), exp_vec(6, 4, c));
    end
    chk("w6h4_tap_r1c3", exp_vec(6, 4, 7 * 11 + 1), pack(9, 0, 0, 0, 0, 0, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for the shared 3x3 convolution datapath.
- Walks a 3x3 window over an IMG_W x IMG_H image held in pixel memory, with no padding (valid-only).
- Per output pixel: issues pixel-memory and kernel-coefficient addresses, drives the shared MAC's load/accumulate controls, then commands a result write into the output buffer that the infer/addr readout path serves.
- Handshake with the host: start/busy/done, plus an abort.

Parameters:
- IMG_W, 5, image width in pixels (>=3)
- IMG_H, 5, image height in pixels (>=3)
- PIX_AW, 5, pixel-memory address width, >= clog2(IMG_W*IMG_H)
- RES_AW, 4, result-buffer address width, >= clog2((IMG_W-2)*(IMG_H-2))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a full-image pass; sampled only in IDLE
- abort  in  1  abandon the current pass
- pix_addr  out  PIX_AW  pixel-memory read address; data returns 1 cycle later to the datapath
- coef_idx  out  4  kernel coefficient index 0..8; registered alongside pix_addr
- mac_en  out  1  datapath consumes returned pixel x coefficient this cycle
- mac_first  out  1  with mac_en: load the product instead of accumulating
- res_we  out  1  write the MAC result into the output buffer
- res_addr  out  RES_AW  output-buffer write address
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the final result write

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE
  - all outputs 0
  - row, col, ky, kx counters 0
- States: IDLE, TAP, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> TAP next cycle, with row=col=ky=kx=0 and busy=1.
- TAP (9 cycles, one per tap):
  - pix_addr = (row+ky)*IMG_W + (col+kx)
  - coef_idx = ky*3 + kx
  - kx increments 0..2; on wrap it clears and ky increments.
  - After the tap with ky=2, kx=2 -> DRAIN.
  - Addresses come from incremental counters (base + offset adds); no multipliers.
- mac_en is pix-address-valid delayed one cycle: high in TAP cycles 2..9 and in DRAIN. mac_first is high only on the first of these.
- DRAIN (1 cycle):
  - last mac_en.
  - Next state WRITE.
- WRITE (1 cycle):
  - res_we=1
  - res_addr = row*(IMG_W-2) + col, held as its own incrementing counter.
  - Then col increments; at col=IMG_W-3 it wraps to 0 and row increments.
  - If the last output (row=IMG_H-3, col=IMG_W-3) was just written -> DONE; else -> TAP.
- DONE:
  - done=1 and busy=0 for one cycle.
  - Then IDLE.
- Latency: 11 cycles per output. Defaults give 9 outputs, 99 cycles from the first TAP to the last WRITE, and done in the cycle after that.
- start while busy: ignored. start in the DONE cycle: ignored. start held high through the return to IDLE: starts a new pass.
- abort=1 in any non-IDLE state:
  - next cycle IDLE, busy=0, mac_en=0
  - no res_we, no done
  - counters cleared
  - abort has priority over every transition, including WRITE → DONE.
- abort in IDLE: no effect; abort has priority over a simultaneous start.
- pix_addr, coef_idx and res_addr are 0 whenever the corresponding valid is low.

Decomposition:
- Package conv_pkg:
  - state enum
  - KSIZE=3 and NTAPS=9
  - MAC_LAT=1 (memory read latency)
- One sub-module: conv_tap_gen.
  - Holds the window/tap counters and produces pix_addr/coef_idx and last-tap/last-output flags.
  - The parent holds the FSM, the mac_en/mac_first delay pipe, and res_addr/handshake.

Test Plan:
- Reset mid-pass: assert rst low during TAP of output 3 → all outputs 0 immediately. After release, state is IDLE and a new start begins at pix_addr 0.
- Full pass, defaults, pixel mem[i]=i, all coefficients 1, bench MAC model:
  - output 0: pix_addr sequence 0,1,2,5,6,7,10,11,12; result 54
  - output 8: pix_addr sequence 12,13,14,17,18,19,22,23,24; result 162
  - res_addr 0..8 in order
  - done exactly 100 cycles after the start edge
- mac_en/mac_first timing: mac_first coincides with the first mac_en, one cycle after pix_addr=0. For each output, exactly 9 mac_en cycles and 1 res_we.
- start pulsed again at cycle 40 while busy → no effect. Sequence and done timing identical to the full-pass scenario.
- abort during the WRITE cycle of output 8 → no res_we, no done pulse, IDLE next cycle, busy=0.
- IMG_W=6, IMG_H=4:
  - 8 outputs
  - output (row1,col3) taps start at pix_addr 9
  - res_addr 7
  - done after 88 working cycles
